// File: rtl/i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// i2s_rx_fifo
// Receive-side frame buffer behind the I2S core. Each stereo frame presented
// with i_audio_valid is stored in a DEPTH-entry first-word-fall-through FIFO
// and handed to a consumer over a valid/ready handshake. Frames arriving while
// the FIFO is full (and nothing is popped that cycle) are dropped, which sets
// a sticky overflow flag and bumps a saturating drop counter.
//
// Ports
//   i_clk_12_288   sole clock, all state changes on its rising edge
//   i_reset        synchronous active-high reset, highest priority
//   i_audio_l/r    received left/right sample, qualified by i_audio_valid
//   i_audio_valid  one-cycle strobe per received frame (push)
//   o_audio_l/r    frame at FIFO head (held when o_audio_valid=0)
//   o_audio_valid  head frame available
//   i_audio_ready  consumer takes the head frame this cycle
//   o_level        frames stored, 0..DEPTH
//   o_full/o_empty level == DEPTH / level == 0
//   o_overflow     sticky: a frame has been dropped since the last clear
//   o_drop_count   dropped frames, saturating at all-ones
//   i_clear_ovf    clears o_overflow and o_drop_count (a same-cycle drop wins)
// -----------------------------------------------------------------------------
module i2s_rx_fifo #(
    parameter int DATA_BIT = 24,
    parameter int DEPTH    = 8,
    parameter int DROP_W   = 16
) (
    input  logic                       i_clk_12_288,
    input  logic                       i_reset,
    input  logic [DATA_BIT-1:0]        i_audio_l,
    input  logic [DATA_BIT-1:0]        i_audio_r,
    input  logic                       i_audio_valid,
    output logic [DATA_BIT-1:0]        o_audio_l,
    output logic [DATA_BIT-1:0]        o_audio_r,
    output logic                       o_audio_valid,
    input  logic                       i_audio_ready,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_overflow,
    output logic [DROP_W-1:0]          o_drop_count,
    input  logic                       i_clear_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = 2 * DATA_BIT;

    logic [EW-1:0]       mem_r [DEPTH];
    logic [PW-1:0]       wr_ptr_r;
    logic [PW-1:0]       rd_ptr_r;
    logic [LW-1:0]       level_r;
    logic                full_r;
    logic                empty_r;
    logic                valid_r;
    logic [EW-1:0]       head_r;
    logic                overflow_r;
    logic [DROP_W-1:0]   drop_cnt_r;

    logic                pop_s;
    logic                push_acc_s;
    logic                drop_s;
    logic [EW-1:0]       wdata_s;
    logic [LW-1:0]       level_nxt_s;
    logic [PW-1:0]       rd_nxt_s;
    logic [EW-1:0]       head_nxt_s;
    logic                overflow_nxt_s;
    logic [DROP_W-1:0]   drop_cnt_nxt_s;

    // Handshake decode, level/pointer/head look-ahead and overflow bookkeeping
    always_comb begin
        pop_s          = valid_r & i_audio_ready;
        // A full FIFO still accepts a frame when the head leaves in the same cycle
        push_acc_s     = i_audio_valid & (~full_r | pop_s);
        drop_s         = i_audio_valid & full_r & ~pop_s;
        wdata_s        = {i_audio_l, i_audio_r};
        level_nxt_s    = level_r;
        rd_nxt_s       = rd_ptr_r;
        head_nxt_s     = head_r;
        overflow_nxt_s = overflow_r;
        drop_cnt_nxt_s = drop_cnt_r;

        case ({push_acc_s, pop_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase

        if (pop_s) begin
            rd_nxt_s = rd_ptr_r + PW'(1);
        end else begin
            rd_nxt_s = rd_ptr_r;
        end

        // The head register is loaded with whatever will sit at the read pointer
        // after this edge; a frame written into that slot this cycle is taken
        // from the input because the array write has not happened yet.
        if (level_nxt_s != LW'(0)) begin
            if (push_acc_s && (wr_ptr_r == rd_nxt_s)) begin
                head_nxt_s = wdata_s;
            end else begin
                head_nxt_s = mem_r[rd_nxt_s];
            end
        end else begin
            head_nxt_s = head_r;
        end

        // A drop in the clearing cycle wins and restarts the count at one
        if (drop_s) begin
            overflow_nxt_s = 1'b1;
            if (i_clear_ovf) begin
                drop_cnt_nxt_s = DROP_W'(1);
            end else if (drop_cnt_r != {DROP_W{1'b1}}) begin
                drop_cnt_nxt_s = drop_cnt_r + DROP_W'(1);
            end else begin
                drop_cnt_nxt_s = drop_cnt_r;
            end
        end else if (i_clear_ovf) begin
            overflow_nxt_s = 1'b0;
            drop_cnt_nxt_s = '0;
        end else begin
            overflow_nxt_s = overflow_r;
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Frame storage; contents need no reset because pointers define validity
    always_ff @(posedge i_clk_12_288) begin
        if (push_acc_s && !i_reset) begin
            mem_r[wr_ptr_r] <= wdata_s;
        end
    end

    // Control state, flags and registered head frame
    always_ff @(posedge i_clk_12_288) begin
        if (i_reset) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            empty_r    <= 1'b1;
            valid_r    <= 1'b0;
            head_r     <= '0;
            overflow_r <= 1'b0;
            drop_cnt_r <= '0;
        end else begin
            if (push_acc_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r   <= rd_nxt_s;
            level_r    <= level_nxt_s;
            full_r     <= (level_nxt_s == LW'(DEPTH));
            empty_r    <= (level_nxt_s == LW'(0));
            valid_r    <= (level_nxt_s != LW'(0));
            head_r     <= head_nxt_s;
            overflow_r <= overflow_nxt_s;
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

    assign o_audio_l     = head_r[EW-1:DATA_BIT];
    assign o_audio_r     = head_r[DATA_BIT-1:0];
    assign o_audio_valid = valid_r;
    assign o_level       = level_r;
    assign o_full        = full_r;
    assign o_empty       = empty_r;
    assign o_overflow    = overflow_r;
    assign o_drop_count  = drop_cnt_r;

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_fifo
// Directed bench for i2s_rx_fifo. Stimulus pushes each frame it expects the
// FIFO to accept into a queue; a monitor running on the falling edge pops and
// compares whenever the DUT hands a frame over (valid & ready). Status outputs
// are checked directly against hand-computed values.
// -----------------------------------------------------------------------------
module tb_i2s_rx_fifo;

    logic        clk;
    logic        rst;
    logic [23:0] in_l;
    logic [23:0] in_r;
    logic        in_valid;
    logic [23:0] out_l;
    logic [23:0] out_r;
    logic        out_valid;
    logic        ready;
    logic [3:0]  level;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [15:0] drops;
    logic        clr;

    int          checks = 0;
    int          errors = 0;
    logic [47:0] exp_q [$];

    i2s_rx_fifo #(.DATA_BIT(24), .DEPTH(8), .DROP_W(16)) dut (
        .i_clk_12_288  (clk),
        .i_reset       (rst),
        .i_audio_l     (in_l),
        .i_audio_r     (in_r),
        .i_audio_valid (in_valid),
        .o_audio_l     (out_l),
        .o_audio_r     (out_r),
        .o_audio_valid (out_valid),
        .i_audio_ready (ready),
        .o_level       (level),
        .o_full        (full),
        .o_empty       (empty),
        .o_overflow    (ovf),
        .o_drop_count  (drops),
        .i_clear_ovf   (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one frame for one cycle; record it as expected output if it should be kept
    task automatic push(input logic [23:0] l, input logic [23:0] r, input bit keep);
        in_l     = l;
        in_r     = r;
        in_valid = 1'b1;
        if (keep) exp_q.push_back({l, r});
        step();
        in_valid = 1'b0;
    endtask

    // Monitor: the handshake is sampled half a cycle before the edge that completes it
    always @(negedge clk) begin
        if (!rst && out_valid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %h_%h expected no frame", out_l, out_r);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({out_l, out_r} !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %h_%h expected %h_%h",
                             out_l, out_r, e[47:24], e[23:0]);
                end
            end
        end
    end

    initial begin
        logic [23:0] nv;
        rst = 1'b1; in_l = '0; in_r = '0; in_valid = 1'b0; ready = 1'b0; clr = 1'b0;

        // Reset then idle
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_drops", 32'(drops), 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        // Single frame latency
        push(24'h123456, 24'hABCDEF, 1'b1);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_l", 32'(out_l), 32'h123456);
        chk("lat_r", 32'(out_r), 32'hABCDEF);
        chk("lat_level", 32'(level), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("lat_empty", 32'(empty), 32'd1);
        chk("lat_valid0", 32'(out_valid), 32'd0);

        // Fill in order
        for (int n = 0; n < 8; n++) begin
            nv = 24'(n);
            push(nv, ~nv, 1'b1);
            chk("fill_level", 32'(level), 32'(n + 1));
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_head_l", 32'(out_l), 32'd0);

        // Overflow: three dropped frames, contents untouched
        for (int n = 8; n < 11; n++) begin
            nv = 24'(n);
            push(nv, ~nv, 1'b0);
        end
        chk("ovf_flag", 32'(ovf), 32'd1);
        chk("ovf_drops", 32'(drops), 32'd3);
        chk("ovf_level", 32'(level), 32'd8);
        chk("ovf_head_l", 32'(out_l), 32'd0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_flag", 32'(ovf), 32'd0);
        chk("clr_drops", 32'(drops), 32'd0);
        // Drop coinciding with clear
        clr = 1'b1;
        push(24'd11, ~24'd11, 1'b0);
        clr = 1'b0;
        chk("clrdrop_flag", 32'(ovf), 32'd1);
        chk("clrdrop_drops", 32'(drops), 32'd1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr2_drops", 32'(drops), 32'd0);

        // Full push+pop: frame 0 leaves, 00AAAA goes in behind frame 7
        ready = 1'b1;
        push(24'h00AAAA, 24'h005555, 1'b1);
        ready = 1'b0;
        chk("pp_level", 32'(level), 32'd8);
        chk("pp_full", 32'(full), 32'd1);
        chk("pp_ovf", 32'(ovf), 32'd0);
        chk("pp_drops", 32'(drops), 32'd0);
        chk("pp_head_l", 32'(out_l), 32'd1);

        // Drain: frames 1..7 then 00AAAA, level counting down
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("drain_level", 32'(level), 32'(7 - i));
        end
        ready = 1'b0;
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_q", 32'(exp_q.size()), 32'd0);

        // Reset mid-stream
        for (int n = 0; n < 5; n++) begin
            nv = 24'h000100 + 24'(n);
            push(nv, ~nv, 1'b1);
        end
        chk("mid_level", 32'(level), 32'd5);
        rst = 1'b1;
        exp_q.delete();
        step();
        rst = 1'b0;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_drops", 32'(drops), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        push(24'h777777, 24'h888888, 1'b1);
        chk("post_level", 32'(level), 32'd1);
        chk("post_l", 32'(out_l), 32'h777777);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("post_empty", 32'(empty), 32'd1);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx_fifo.md
Name: i2s_rx_fifo

Overview:
- Downstream stage of the I2S receive path. Captures each stereo frame that the I2S core presents on its received-audio outputs when its per-frame valid strobe fires.
- Buffers frames in a DEPTH-entry first-word-fall-through FIFO and delivers them to a consumer (DSP or loopback) over a valid/ready handshake.
- Reports fill level, and overflow as a sticky flag plus a drop counter.

Parameters:
DATA_BIT, 24, width of one audio channel sample; matches the I2S core sample width.
DEPTH, 8, FIFO depth in stereo frames; power of two, minimum 2.
DROP_W, 16, width of the dropped-frame counter.

Ports:
i_clk_12_288  in  1  12.288 MHz system/audio clock, sole clock.
i_reset  in  1  synchronous, active-high reset.
i_audio_l  in  DATA_BIT  received left sample from the I2S core.
i_audio_r  in  DATA_BIT  received right sample from the I2S core.
i_audio_valid  in  1  one-cycle strobe; left/right pair is valid this cycle.
o_audio_l  out  DATA_BIT  left sample at FIFO head.
o_audio_r  out  DATA_BIT  right sample at FIFO head.
o_audio_valid  out  1  head frame available.
i_audio_ready  in  1  consumer accepts head frame this cycle.
o_level  out  $clog2(DEPTH)+1  number of frames stored, 0..DEPTH.
o_full  out  1  o_level == DEPTH.
o_empty  out  1  o_level == 0.
o_overflow  out  1  sticky: at least one frame dropped since last clear.
o_drop_count  out  DROP_W  frames dropped, saturating at all-ones.
i_clear_ovf  in  1  one-cycle clear of o_overflow and o_drop_count.

Behaviour:
- All state changes on the rising edge of i_clk_12_288. Single clock, no CDC.
- Reset (i_reset=1, synchronous): pointers=0, o_level=0, o_empty=1, o_full=0, o_audio_valid=0, o_overflow=0, o_drop_count=0. o_audio_l/r=0.
- Reset has priority over every other input. Reset mid-stream discards all stored frames.
- Storage: DEPTH x (2*DATA_BIT) array. Left sample occupies the upper half of an entry, right the lower half. Write and read pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- push = i_audio_valid. pop = o_audio_valid & i_audio_ready.
- Push when not full:
  - Frame written at the write pointer; write pointer +1.
  - A frame pushed into an empty FIFO appears on o_audio_l/r with o_audio_valid=1 on the next cycle (1-cycle latency). No same-cycle bypass.
- Push when full, no pop in the same cycle:
  - Frame discarded; FIFO contents unchanged.
  - o_overflow <= 1.
  - o_drop_count <= o_drop_count+1, saturating at 2^DROP_W-1.
- Push when full with a pop in the same cycle: frame accepted, o_level stays DEPTH, no drop.
- Pop: read pointer +1. The next head frame (if any) is visible the following cycle.
- o_audio_l/r hold stable while o_audio_valid=1 and i_audio_ready=0.
- When o_audio_valid=0, o_audio_l/r are don't-care; the implementation holds the last value.
- o_level accounting:
  - +1 on an accepted push without pop.
  - -1 on a pop without push.
  - Unchanged on push+pop or on neither.
- o_full, o_empty and o_audio_valid are registered and consistent with o_level every cycle; o_audio_valid = ~o_empty.
- i_clear_ovf=1 sets o_overflow<=0 and o_drop_count<=0.
- If a drop occurs in the same cycle as i_clear_ovf, the drop wins: o_overflow<=1, o_drop_count<=1.
- i_audio_ready is ignored while o_audio_valid=0. A pop is never issued on an empty FIFO.
- Nominal rate: one push per 256 clocks (48 kHz frame), so a consumer that is occasionally stalled never overflows with DEPTH>=2.

Test Plan:
- Reset then idle: after 3 cycles with i_reset=1, then 10 cycles idle -> o_empty=1, o_level=0, o_audio_valid=0, o_overflow=0, o_drop_count=0.
- Single frame latency: push L=24'h123456, R=24'hABCDEF with i_audio_ready=0 -> next cycle o_audio_valid=1, o_audio_l=24'h123456, o_audio_r=24'hABCDEF, o_level=1. Assert ready for one cycle -> o_empty=1 the cycle after.
- Fill and order: push frames L=n, R=~n for n=0..7 with ready=0 -> o_full=1, o_level=8. Then hold ready=1 -> frames pop in order 0..7, o_level counts 7..0.
- Overflow: with FIFO full, push 3 more frames (L=8,9,10) -> o_overflow=1, o_drop_count=3, contents still 0..7.
  - Pulse i_clear_ovf -> both cleared.
  - Repeat with a drop coinciding with the clear -> o_overflow=1, o_drop_count=1.
- Full push+pop: FIFO full, push L=24'h00AAAA in the same cycle that ready=1 -> no drop, o_level stays 8, frame 0 consumed, 24'h00AAAA becomes the 8th entry after wrap.
- Reset mid-stream: o_level=5 with i_reset asserted for 1 cycle -> next cycle o_level=0, o_audio_valid=0, o_drop_count=0. A subsequent push reads back correctly from pointer 0.
